// File: rtl/ll_window_accum.sv
// Sliding-window line-length accumulator: keeps the last win_len difference samples in a
// circular buffer and emits their running sum plus a registered threshold-crossing pulse.
module ll_window_accum #(
  parameter int data_width = 32,
  parameter int win_len    = 16,
  parameter int addr_width = 4,
  parameter int sum_width  = 36
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] din,
  input  logic                  din_valid,
  input  logic [sum_width-1:0]  thresh,
  output logic [sum_width-1:0]  ll_sum,
  output logic                  ll_valid,
  output logic                  detect,
  output logic                  full
);

  typedef enum logic {FILL, RUN} state_t;

  localparam logic [addr_width-1:0] LAST_IDX = addr_width'(win_len - 1);

  state_t                state_q, state_d;
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] fill_cnt_q, fill_cnt_d;
  logic [sum_width-1:0]  acc_q, acc_d;
  logic [sum_width-1:0]  acc_new, sum_d;
  logic [sum_width-1:0]  din_ext, old_ext;
  logic                  valid_d, detect_d, full_d, wr_en;

  logic [data_width-1:0] mem [0:win_len-1];

  // The evicted sample is read combinationally before the same-edge write replaces it.
  assign din_ext = sum_width'(din);
  assign old_ext = (state_q == RUN) ? sum_width'(mem[wr_ptr_q]) : '0;
  assign acc_new = acc_q + din_ext - old_ext;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    acc_d      = acc_q;
    sum_d      = ll_sum;
    valid_d    = 1'b0;
    detect_d   = 1'b0;
    full_d     = full;
    wr_en      = 1'b0;
    if (din_valid) begin
      wr_en    = 1'b1;
      acc_d    = acc_new;
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + addr_width'(1);
      case (state_q)
        FILL: begin
          fill_cnt_d = fill_cnt_q + addr_width'(1);
          if (fill_cnt_q == LAST_IDX) begin
            state_d  = RUN;
            full_d   = 1'b1;
            valid_d  = 1'b1;
            sum_d    = acc_new;
            detect_d = (acc_new > thresh);
          end
        end
        RUN: begin
          valid_d  = 1'b1;
          sum_d    = acc_new;
          detect_d = (acc_new > thresh);
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      acc_q      <= '0;
      ll_sum     <= '0;
      ll_valid   <= 1'b0;
      detect     <= 1'b0;
      full       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      acc_q      <= acc_d;
      ll_sum     <= sum_d;
      ll_valid   <= valid_d;
      detect     <= detect_d;
      full       <= full_d;
    end
  end

  // Sample storage is never cleared; FILL never reads a stale slot.
  always_ff @(posedge clk) begin
    if (wr_en && !rst)
      mem[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_ll_window_accum.sv
// Drives three window configurations (16, 4 and 3 samples) with one shared stream and checks
// every output each cycle against a history-queue model of the last-N-sample sum.
module tb_ll_window_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic [35:0] thresh;

  logic [35:0] sum16;
  logic [33:0] sum4, sum3;
  logic        valid16, valid4, valid3;
  logic        det16, det4, det3;
  logic        full16, full4, full3;

  int tests = 0;
  int fails = 0;

  longint unsigned hist[$];
  int              cnt;
  int              len  [3] = '{16, 4, 3};
  longint unsigned mask [3] = '{64'hF_FFFF_FFFF, 64'h3_FFFF_FFFF, 64'h3_FFFF_FFFF};
  longint unsigned e_sum[3];
  bit              e_valid[3], e_det[3], e_full[3];

  always #5 clk = ~clk;

  ll_window_accum u16 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .thresh(thresh),
    .ll_sum(sum16), .ll_valid(valid16), .detect(det16), .full(full16)
  );

  ll_window_accum #(.data_width(32), .win_len(4), .addr_width(2), .sum_width(34)) u4 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .thresh(thresh[33:0]),
    .ll_sum(sum4), .ll_valid(valid4), .detect(det4), .full(full4)
  );

  ll_window_accum #(.data_width(32), .win_len(3), .addr_width(2), .sum_width(34)) u3 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .thresh(thresh[33:0]),
    .ll_sum(sum3), .ll_valid(valid3), .detect(det3), .full(full3)
  );

  task automatic checkOutput(input string tag, input longint unsigned act,
                             input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: the output sum is just the sum of the most recent N accepted samples.
  task automatic modelStep(input bit r, input bit v, input logic [31:0] d,
                           input logic [35:0] t);
    longint unsigned s;
    if (r) begin
      hist.delete();
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
        e_sum[i] = 0; e_valid[i] = 0; e_det[i] = 0; e_full[i] = 0;
      end
    end else if (v) begin
      hist.push_back(longint'(d));
      if (hist.size() > 16) void'(hist.pop_front());
      if (cnt < 1000) cnt++;
      for (int i = 0; i < 3; i++) begin
        if (cnt >= len[i]) begin
          s = 0;
          for (int k = hist.size() - len[i]; k < hist.size(); k++) s += hist[k];
          e_sum[i]   = s;
          e_valid[i] = 1;
          e_det[i]   = (s > (longint'(t) & mask[i]));
          e_full[i]  = 1;
        end else begin
          e_valid[i] = 0;
          e_det[i]   = 0;
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        e_valid[i] = 0; e_det[i] = 0;
      end
    end
  endtask

  task automatic checkInst(input string nm, input int i, input longint unsigned s,
                           input bit vl, input bit dt, input bit fl);
    checkOutput({nm, ".ll_sum"}, s, e_sum[i]);
    checkOutput({nm, ".ll_valid"}, longint'(vl), longint'(e_valid[i]));
    checkOutput({nm, ".detect"}, longint'(dt), longint'(e_det[i]));
    checkOutput({nm, ".full"}, longint'(fl), longint'(e_full[i]));
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [31:0] d,
                               input logic [35:0] t);
    @(negedge clk);
    rst       = r;
    din_valid = v;
    din       = v ? d : 'x;
    thresh    = t;
    @(posedge clk);
    modelStep(r, v, d, t);
    #1;
    checkInst("w16", 0, longint'(sum16), valid16, det16, full16);
    checkInst("w4",  1, longint'(sum4),  valid4,  det4,  full4);
    checkInst("w3",  2, longint'(sum3),  valid3,  det3,  full3);
  endtask

  initial begin
    logic [31:0] d;
    logic [35:0] t;
    bit          r, v;
    rst = 1'b1; din_valid = 1'b0; din = '0; thresh = '0;
    cnt = 0;

    applyStimulus(1, 0, 0, 15);
    applyStimulus(1, 0, 0, 15);

    for (int i = 1; i <= 6; i++) begin
      applyStimulus(0, 1, 32'(i), 15);
      if (i == 4) checkOutput("tp1.sum4", longint'(sum4), 10);
      if (i == 5) checkOutput("tp2.det4_lo", longint'(det4), 0);
    end
    checkOutput("tp2.sum4", longint'(sum4), 18);
    checkOutput("tp2.det4_hi", longint'(det4), 1);

    applyStimulus(1, 0, 0, 15);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(0, 1, 32'(i), 15);
      for (int g = 0; g < 3; g++) applyStimulus(0, 0, 0, 15);
    end
    checkOutput("tp3.sum4_held", longint'(sum4), 18);

    applyStimulus(1, 1, 9, 15);
    checkOutput("tp5.full4", longint'(full4), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 7, 15);
      if (i == 2) checkOutput("tp5.valid4_early", longint'(valid4), 0);
    end
    checkOutput("tp5.sum4", longint'(sum4), 28);

    applyStimulus(1, 0, 0, 100);
    for (int i = 1; i <= 6; i++) applyStimulus(0, 1, 32'(10 * i), 100);
    checkOutput("tp4.sum3", longint'(sum3), 150);

    applyStimulus(1, 0, 0, 36'hF_0000_0000);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 32'hFFFF_FFFF, 36'hF_0000_0000);
    checkOutput("tp6.sum16_full", longint'(sum16), 64'hF_FFFF_FFF0);
    applyStimulus(0, 1, 0, 36'hF_0000_0000);
    checkOutput("tp6.sum16_drop", longint'(sum16), 64'hE_FFFF_FFF1);

    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       d = $urandom_range(0, 100);
        1:       d = 32'hFFFF_FFFF;
        default: d = $urandom();
      endcase
      if ($urandom_range(0, 1) == 0) t = 36'($urandom_range(0, 400));
      else                           t = {4'($urandom_range(0, 15)), 32'($urandom())};
      applyStimulus(r, v, d, t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
